// File: rtl/vram_arbiter.sv
// Single-port video memory arbiter: VGA scan-out has priority, CPU writes are posted
// through a small FIFO, CPU reads block until served, and a starvation guard forces CPU slots.
module vram_arbiter #(
    parameter int AW           = 17,
    parameter int DW           = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 800
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    output logic          vga_miss,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW:0]   PTR_ONE    = (PW + 1)'(1);

    typedef enum logic [1:0] {IDLE, RD_PEND, RD_DATA} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_DRAIN, GNT_READ} grant_t;

    state_t        state, state_next;
    grant_t        grant;

    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;

    logic [AW-1:0] rd_addr;
    logic [CW-1:0] starve_cnt;
    logic          wr_ack_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] vga_hold;
    logic          last_vga;

    logic          sample, wr_accept, rd_accept;
    logic          cpu_work, forced, cpu_slot;

    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

        // The ack cycle must not sample, or a held request would be accepted twice.
        sample    = (state == IDLE) && !wr_ack_q;
        wr_accept = sample && cpu_req && cpu_we && !fifo_full;
        rd_accept = sample && cpu_req && !cpu_we;

        cpu_work = !fifo_empty || (state == RD_PEND);
        forced   = (starve_cnt == STARVE_MAX) && cpu_work;

        // Forced slots serve the FIFO head first so reads never overtake posted writes.
        grant = GNT_NONE;
        if (forced)
            grant = fifo_empty ? GNT_READ : GNT_DRAIN;
        else if (vga_req)
            grant = GNT_VGA;
        else if (!fifo_empty)
            grant = GNT_DRAIN;
        else if (state == RD_PEND)
            grant = GNT_READ;
        cpu_slot = (grant == GNT_DRAIN) || (grant == GNT_READ);

        state_next = state;
        case (state)
            IDLE:    if (rd_accept) state_next = RD_PEND;
            RD_PEND: if (grant == GNT_READ) state_next = RD_DATA;
            RD_DATA: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        mem_addr  = vga_addr;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (grant)
            GNT_DRAIN: begin
                mem_addr  = fifo_addr[rd_ptr[PW-1:0]];
                mem_wdata = fifo_data[rd_ptr[PW-1:0]];
                mem_we    = 1'b1;
            end
            GNT_READ: mem_addr = rd_addr;
            default:  ;
        endcase

        // Read data is only valid the cycle after the read slot, so the read ack and
        // its data come straight from the memory in RD_DATA; rdata_q holds it afterwards.
        cpu_ack   = wr_ack_q || (state == RD_DATA);
        cpu_rdata = (state == RD_DATA) ? mem_rdata : rdata_q;
        vga_data  = last_vga ? mem_rdata : vga_hold;
        cpu_busy  = fifo_full;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            wr_ack_q   <= 1'b0;
            rdata_q    <= '0;
            vga_miss   <= 1'b0;
            vga_hold   <= '0;
            last_vga   <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_accept)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (grant == GNT_DRAIN)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (rd_accept)
                rd_addr <= cpu_addr;
            wr_ack_q <= wr_accept;
            if (state == RD_DATA)
                rdata_q <= mem_rdata;
            vga_miss <= forced && vga_req;
            last_vga <= (grant == GNT_VGA);
            if (last_vga)
                vga_hold <= mem_rdata;
            if (!cpu_work || cpu_slot)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (wr_accept) begin
            fifo_addr[wr_ptr[PW-1:0]] <= cpu_addr;
            fifo_data[wr_ptr[PW-1:0]] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a queue-based model of the arbitration rules
// predicts every memory access, ack, busy flag and VGA data value cycle by cycle.
module tb_vram_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    localparam int S_NONE  = 0;
    localparam int S_VGA   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_READ  = 3;

    logic          CLOCK = 1'b0;
    logic          RESET_N;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    always #5 CLOCK = ~CLOCK;

    vram_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_miss(vga_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous RAM, read-before-write, one cycle read latency.
    logic [DW-1:0] tbmem [0:(1<<AW)-1];
    always @(posedge CLOCK) begin
        mem_rdata <= tbmem[mem_addr];
        if (mem_we)
            tbmem[mem_addr] = mem_wdata;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];
    bit            m_rd_pend, m_rd_data, m_wr_ack, m_last_vga, m_miss, m_prev_ack;
    logic [AW-1:0] m_rd_addr;
    logic [DW-1:0] m_rd_exp, m_vga_val, m_hold;
    int            m_starve;
    bit            cpu_active;
    logic [AW-1:0] vga_seq;

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        m_rd_pend  = 0;
        m_rd_data  = 0;
        m_wr_ack   = 0;
        m_last_vga = 0;
        m_miss     = 0;
        m_hold     = '0;
        m_vga_val  = '0;
        m_starve   = 0;
    endtask

    task automatic drive(input int vga_pct, input bit seq_addr, input bit allow_reset);
        int unsigned sel;
        RESET_N = !(allow_reset && ($urandom_range(0, 199) == 0));
        vga_req = ($urandom_range(0, 99) < vga_pct);
        if (seq_addr) begin
            vga_addr = vga_seq;
            vga_seq  = vga_seq + 1'b1;
        end else begin
            vga_addr = AW'($urandom);
        end
        // A completed request drops after its ack; a new one may start right away.
        if (m_prev_ack)
            cpu_active = 0;
        if (!cpu_active && ($urandom_range(0, 99) < 60)) begin
            cpu_active = 1;
            sel        = $urandom_range(0, 15);
            cpu_we     = ($urandom_range(0, 99) < 60);
            cpu_addr   = (sel < 8) ? AW'(17'h00100 + sel) : AW'(17'h01F00 + sel - 8);
            cpu_wdata  = DW'($urandom);
        end
        cpu_req = cpu_active;
    endtask

    task automatic model_cycle();
        int            qs, slot;
        bit            busy, ack, sample, work, forced;
        logic [AW-1:0] ea;
        logic [DW-1:0] ev, rexp;

        qs     = q_addr.size();
        busy   = (qs == DEPTH);
        ack    = m_wr_ack || m_rd_data;
        sample = !m_rd_pend && !m_rd_data && !ack;
        work   = (qs > 0) || m_rd_pend;
        forced = (m_starve == LIMIT) && work;

        if (forced)             slot = (qs > 0) ? S_DRAIN : S_READ;
        else if (vga_req)       slot = S_VGA;
        else if (qs > 0)        slot = S_DRAIN;
        else if (m_rd_pend)     slot = S_READ;
        else                    slot = S_NONE;

        ea = (slot == S_DRAIN) ? q_addr[0] : (slot == S_READ) ? m_rd_addr : vga_addr;
        ev = m_last_vga ? m_vga_val : m_hold;

        check("cpu_busy", 32'(cpu_busy), 32'(busy));
        check("cpu_ack",  32'(cpu_ack),  32'(ack));
        check("mem_we",   32'(mem_we),   32'(slot == S_DRAIN));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("vga_data", 32'(vga_data), 32'(ev));
        check("vga_miss", 32'(vga_miss), 32'(m_miss));
        if (slot == S_DRAIN)
            check("mem_wdata", 32'(mem_wdata), 32'(q_data[0]));
        if (m_rd_data)
            check("cpu_rdata", 32'(cpu_rdata), 32'(m_rd_exp));

        m_prev_ack = ack;
        if (!RESET_N) begin
            model_reset();
            return;
        end

        // A read returns the newest posted value for its address, else the memory contents.
        rexp = tbmem[cpu_addr];
        for (int i = 0; i < qs; i++)
            if (q_addr[i] == cpu_addr)
                rexp = q_data[i];

        m_hold     = ev;
        m_last_vga = (slot == S_VGA);
        if (slot == S_VGA)
            m_vga_val = tbmem[vga_addr];
        m_miss = forced && vga_req;

        if (!work || slot == S_DRAIN || slot == S_READ)
            m_starve = 0;
        else if (m_starve < LIMIT)
            m_starve++;

        m_wr_ack  = 0;
        m_rd_data = 0;
        if (slot == S_DRAIN) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (slot == S_READ) begin
            m_rd_pend = 0;
            m_rd_data = 1;
        end
        if (sample && cpu_req && cpu_we && !busy) begin
            q_addr.push_back(cpu_addr);
            q_data.push_back(cpu_wdata);
            m_wr_ack = 1;
        end
        if (sample && cpu_req && !cpu_we) begin
            m_rd_pend = 1;
            m_rd_addr = cpu_addr;
            m_rd_exp  = rexp;
        end
    endtask

    initial begin
        int vga_pct [4] = '{100, 0, 60, 95};

        for (int a = 0; a < (1 << AW); a++)
            tbmem[a] = DW'(a + 'h10);

        RESET_N    = 1'b0;
        vga_req    = 1'b0;
        vga_addr   = '0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_active = 0;
        m_prev_ack = 0;
        vga_seq    = '0;
        model_reset();
        repeat (3) @(posedge CLOCK);

        for (int unsigned p = 0; p < 4; p++) begin
            for (int unsigned c = 0; c < 1500; c++) begin
                @(posedge CLOCK);
                #1;
                drive(vga_pct[p], (p == 0), (p >= 2));
                #1;
                model_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
